pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Holds the program counter of the multicycle CPU and consumes the 32-bit next-PC word produced by the PC-source selector.
- Drives that selector's 3-bit select input and decides each cycle whether the PC is written: unconditional writes, resolved conditional branches, or the exception sequence.
- On an exception it saves EPC, requests the exception vector byte from memory, then loads the PC through selector input 4.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
EXC_BASE, 32'h0000_00FD, vector byte address for ExcCode 01; code 10 uses +1, code 11 uses +2

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
NextPC  in  32  selected next-PC word returned from the PC-source selector
PCSrcReq  in  3  select requested by the control unit during normal operation
PCWrite  in  1  unconditional PC write
PCWriteCond  in  1  conditional PC write, qualified by branch test
BranchType  in  2  00 beq, 01 bne, 10 ble, 11 bgt
Zero  in  1  ALU zero flag
GT  in  1  ALU greater-than flag (signed A>B)
ExcReq  in  1  exception request pulse from control
ExcCode  in  2  01 invalid opcode, 10 overflow, 11 divide-by-zero
PC  out  32  program counter register
EPC  out  32  exception PC register
PCSrcSel  out  3  select driven to the PC-source selector
ExcVecAddr  out  32  memory address of the vector byte
ExcMemRead  out  1  memory read strobe for the vector byte
ExcBusy  out  1  high while the exception sequence runs; control must hold

Behaviour:
- Reset (Reset_n=0, async): PC=RESET_PC, EPC=0, state=RUN, saved code=00. Combinational outputs follow state: PCSrcSel=PCSrcReq, ExcMemRead=0, ExcBusy=0, ExcVecAddr=0.
- States: RUN, EXC_SAVE, EXC_FETCH, EXC_LOAD. All registered updates occur on the rising Clk edge.
- Branch condition cond: beq=Zero, bne=~Zero, ble=~GT, bgt=GT.
- RUN:
  - PCSrcSel=PCSrcReq.
  - pc_we = PCWrite | (PCWriteCond & cond); if pc_we, PC<=NextPC.
  - ExcReq=1 with ExcCode!=00: suppress pc_we that cycle (exception has priority over PCWrite and PCWriteCond), latch ExcCode, and go to EXC_SAVE.
  - ExcReq=1 with ExcCode=00: ignored; behaves as a normal RUN cycle.
- EXC_SAVE:
  - EPC<=PC-4 (mod 2^32; PC=0 yields 32'hFFFF_FFFC).
  - ExcMemRead=1.
  - ExcVecAddr = EXC_BASE + (code-1).
  - Go to EXC_FETCH.
- EXC_FETCH:
  - ExcMemRead=1 and ExcVecAddr held, covering the memory's one-cycle read latency.
  - Go to EXC_LOAD.
- EXC_LOAD:
  - PCSrcSel=3'b100 (selector input 4 carries the zero-extended memory byte).
  - PC<=NextPC unconditionally.
  - Go to RUN.
- ExcBusy=1 in EXC_SAVE, EXC_FETCH and EXC_LOAD. PCSrcSel=3'b000 in EXC_SAVE and EXC_FETCH.
- ExcReq, PCWrite and PCWriteCond are ignored outside RUN; the PC holds in EXC_SAVE and EXC_FETCH.
- Latency: exception request to new PC visible = 3 cycles after the request edge; the PC updates at the end of EXC_LOAD.
- ExcReq is accepted again on the first RUN cycle after EXC_LOAD. Back-to-back exceptions are legal.
- Reset asserted mid-sequence: immediately returns to RUN with PC=RESET_PC and EPC=0; the sequence is abandoned.
- EPC changes only in EXC_SAVE.

Test Plan:
- Reset with PCWrite=1, NextPC=32'h4, one edge, then a PCWrite pulse → PC=32'h4 after the edge; 32'h0 during reset.
- PCWriteCond=1, BranchType=00: with Zero=1, NextPC=32'h40, PC becomes 32'h40. With BranchType=11, GT=0, PC is unchanged. Repeat for bne and ble, each taken/not-taken case.
- PC=32'h100; ExcReq=1, ExcCode=10, PCWrite=1 in the same cycle → PC not written that cycle. Then EPC=32'hFC, ExcVecAddr=32'hFE with ExcMemRead high for 2 cycles, PCSrcSel=100 in EXC_LOAD. With NextPC=32'h0000_0077, PC=32'h77, ExcBusy low after 3 cycles.
- ExcReq=1, ExcCode=00 → no state change, EPC unchanged, normal write honoured.
- Reset_n low during EXC_FETCH → PC=0, EPC=0, ExcBusy=0 asynchronously. A new ExcCode=11 then yields ExcVecAddr=32'hFF.
- PC=0, ExcCode=01 → EPC=32'hFFFF_FFFC, ExcVecAddr=32'hFD; ExcReq pulses during EXC_FETCH are ignored.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer, the control unit and the PC-source selector.
// The slave modport is the sequencer side; master is the control/selector side.
interface pc_sequencer_if;
  logic [31:0] NextPC;
  logic [2:0]  PCSrcReq;
  logic        PCWrite;
  logic        PCWriteCond;
  logic [1:0]  BranchType;
  logic        Zero;
  logic        GT;
  logic        ExcReq;
  logic [1:0]  ExcCode;
  logic [31:0] PC;
  logic [31:0] EPC;
  logic [2:0]  PCSrcSel;
  logic [31:0] ExcVecAddr;
  logic        ExcMemRead;
  logic        ExcBusy;

  modport slave (
    input  NextPC, PCSrcReq, PCWrite, PCWriteCond, BranchType, Zero, GT,
           ExcReq, ExcCode,
    output PC, EPC, PCSrcSel, ExcVecAddr, ExcMemRead, ExcBusy
  );

  modport master (
    output NextPC, PCSrcReq, PCWrite, PCWriteCond, BranchType, Zero, GT,
           ExcReq, ExcCode,
    input  PC, EPC, PCSrcSel, ExcVecAddr, ExcMemRead, ExcBusy
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter + exception sequencer; normal writes land on the next edge, exception PC after 3 edges.
// No handshake: ExcBusy tells control to hold while the 3-cycle exception sequence runs.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_BASE = 32'h0000_00FD
) (
  input logic          Clk,
  input logic          Reset_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    EXC_SAVE  = 2'b01,
    EXC_FETCH = 2'b10,
    EXC_LOAD  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  code_q, code_d;

  logic        cond;
  logic        pc_we;
  logic        exc_take;
  logic [31:0] vec_addr;

  logic [2:0]  sel;
  logic        mem_rd;
  logic        busy;
  logic [31:0] vec_out;

  always_comb begin
    cond = 1'b0;
    case (bus.BranchType)
      2'b00:   cond = bus.Zero;
      2'b01:   cond = ~bus.Zero;
      2'b10:   cond = ~bus.GT;
      default: cond = bus.GT;
    endcase
  end

  assign pc_we    = bus.PCWrite | (bus.PCWriteCond & cond);
  assign exc_take = bus.ExcReq & (bus.ExcCode != 2'b00);
  // Vector bytes sit at consecutive addresses, one per nonzero code.
  assign vec_addr = EXC_BASE + {30'd0, code_q} - 32'd1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      epc_q   <= 32'h0000_0000;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    code_d  = code_q;
    sel     = bus.PCSrcReq;
    mem_rd  = 1'b0;
    busy    = 1'b0;
    vec_out = 32'h0000_0000;
    case (state_q)
      RUN: begin
        if (exc_take) begin
          code_d  = bus.ExcCode;
          state_d = EXC_SAVE;
        end else if (pc_we) begin
          pc_d = bus.NextPC;
        end
      end
      EXC_SAVE: begin
        sel     = 3'b000;
        busy    = 1'b1;
        mem_rd  = 1'b1;
        vec_out = vec_addr;
        epc_d   = pc_q - 32'd4;
        state_d = EXC_FETCH;
      end
      EXC_FETCH: begin
        // Address held a second cycle to cover the memory's read latency.
        sel     = 3'b000;
        busy    = 1'b1;
        mem_rd  = 1'b1;
        vec_out = vec_addr;
        state_d = EXC_LOAD;
      end
      EXC_LOAD: begin
        sel     = 3'b100;
        busy    = 1'b1;
        pc_d    = bus.NextPC;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.PC         = pc_q;
  assign bus.EPC        = epc_q;
  assign bus.PCSrcSel   = sel;
  assign bus.ExcVecAddr = vec_out;
  assign bus.ExcMemRead = mem_rd;
  assign bus.ExcBusy    = busy;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for RUN-state writes, hand sequences for exceptions.
module tb_pc_sequencer;
  logic Clk;
  logic Reset_n;
  int   n_total;
  int   n_pass;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC(32'h0000_0000),
    .EXC_BASE(32'h0000_00FD)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        pcwrite;
    logic        pcwritecond;
    logic [1:0]  btype;
    logic        zero;
    logic        gt;
    logic [2:0]  srcreq;
    logic [31:0] nextpc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.ExcReq      = 1'b0;
    bus.ExcCode     = 2'b00;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    // PC starts at 4 when the table runs
    vecs[0] = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 3'b001, 32'h40,  32'h40};
    vecs[1] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 3'b010, 32'h80,  32'h40};
    vecs[2] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 3'b011, 32'h80,  32'h80};
    vecs[3] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 3'b001, 32'h90,  32'h80};
    vecs[4] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 3'b010, 32'h100, 32'h100};
    vecs[5] = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 3'b001, 32'h200, 32'h100};
    vecs[6] = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 32'h300, 32'h300};
    vecs[7] = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 3'b001, 32'h400, 32'h300};
    vecs[8] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 3'b010, 32'h500, 32'h300};
    vecs[9] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3'b010, 32'h100, 32'h100};

    // Reset held across an edge with a write pending
    Reset_n        = 1'b0;
    bus.NextPC     = 32'h4;
    bus.PCSrcReq   = 3'b011;
    bus.BranchType = 2'b00;
    bus.Zero       = 1'b0;
    bus.GT         = 1'b0;
    idle_inputs();
    bus.PCWrite    = 1'b1;
    tick();
    chk("rst_pc",      bus.PC,                 32'h0);
    chk("rst_epc",     bus.EPC,                32'h0);
    chk("rst_sel",     {29'd0, bus.PCSrcSel},  32'h3);
    chk("rst_memrd",   {31'd0, bus.ExcMemRead}, 32'h0);
    chk("rst_busy",    {31'd0, bus.ExcBusy},   32'h0);
    chk("rst_vecaddr", bus.ExcVecAddr,         32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    chk("first_write_pc", bus.PC, 32'h4);

    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      bus.PCWrite     = vecs[i].pcwrite;
      bus.PCWriteCond = vecs[i].pcwritecond;
      bus.BranchType  = vecs[i].btype;
      bus.Zero        = vecs[i].zero;
      bus.GT          = vecs[i].gt;
      bus.PCSrcReq    = vecs[i].srcreq;
      bus.NextPC      = vecs[i].nextpc;
      #1;
      chk($sformatf("vec%0d_sel", i), {29'd0, bus.PCSrcSel}, {29'd0, vecs[i].srcreq});
      tick();
      chk($sformatf("vec%0d_pc", i), bus.PC, vecs[i].exp_pc);
      chk($sformatf("vec%0d_busy", i), {31'd0, bus.ExcBusy}, 32'h0);
    end

    // Exception beats a simultaneous PCWrite; PC=0x100
    @(negedge Clk);
    idle_inputs();
    bus.PCWrite  = 1'b1;
    bus.NextPC   = 32'h555;
    bus.PCSrcReq = 3'b010;
    bus.ExcReq   = 1'b1;
    bus.ExcCode  = 2'b10;
    tick();
    chk("exc_nowrite_pc", bus.PC, 32'h100);
    chk("save_busy",  {31'd0, bus.ExcBusy},    32'h1);
    chk("save_memrd", {31'd0, bus.ExcMemRead}, 32'h1);
    chk("save_addr",  bus.ExcVecAddr,          32'hFE);
    chk("save_sel",   {29'd0, bus.PCSrcSel},   32'h0);
    chk("save_epc_old", bus.EPC,               32'h0);
    @(negedge Clk);
    bus.ExcReq = 1'b0;
    tick();
    chk("fetch_epc",   bus.EPC,                 32'hFC);
    chk("fetch_memrd", {31'd0, bus.ExcMemRead}, 32'h1);
    chk("fetch_addr",  bus.ExcVecAddr,          32'hFE);
    chk("fetch_pc",    bus.PC,                  32'h100);
    @(negedge Clk);
    bus.NextPC = 32'h77;
    tick();
    chk("load_sel",   {29'd0, bus.PCSrcSel},   32'h4);
    chk("load_memrd", {31'd0, bus.ExcMemRead}, 32'h0);
    chk("load_busy",  {31'd0, bus.ExcBusy},    32'h1);
    chk("load_pc",    bus.PC,                  32'h100);
    tick();
    chk("vec_pc",    bus.PC,                 32'h77);
    chk("done_busy", {31'd0, bus.ExcBusy},   32'h0);
    chk("done_sel",  {29'd0, bus.PCSrcSel},  32'h2);

    // ExcCode 00 is not an exception
    @(negedge Clk);
    idle_inputs();
    bus.PCWrite = 1'b1;
    bus.NextPC  = 32'h200;
    bus.ExcReq  = 1'b1;
    tick();
    chk("code0_pc",   bus.PC,               32'h200);
    chk("code0_busy", {31'd0, bus.ExcBusy}, 32'h0);
    chk("code0_epc",  bus.EPC,              32'hFC);

    // Reset during EXC_FETCH abandons the sequence
    @(negedge Clk);
    idle_inputs();
    bus.ExcReq  = 1'b1;
    bus.ExcCode = 2'b01;
    tick();
    @(negedge Clk);
    idle_inputs();
    tick();
    chk("pre_rst_epc",  bus.EPC,              32'h1FC);
    chk("pre_rst_busy", {31'd0, bus.ExcBusy}, 32'h1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_pc",   bus.PC,               32'h0);
    chk("arst_epc",  bus.EPC,              32'h0);
    chk("arst_busy", {31'd0, bus.ExcBusy}, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Code 11 from PC=0: EPC wraps, vector byte at 0xFF
    @(negedge Clk);
    bus.ExcReq  = 1'b1;
    bus.ExcCode = 2'b11;
    tick();
    chk("c3_addr", bus.ExcVecAddr, 32'hFF);
    @(negedge Clk);
    idle_inputs();
    tick();
    chk("c3_epc", bus.EPC, 32'hFFFF_FFFC);
    @(negedge Clk);
    bus.NextPC = 32'h0;
    tick();
    tick();
    chk("c3_pc", bus.PC, 32'h0);

    // Back-to-back: code 01 accepted on first RUN cycle; request in FETCH ignored
    @(negedge Clk);
    bus.ExcReq  = 1'b1;
    bus.ExcCode = 2'b01;
    tick();
    chk("c1_addr", bus.ExcVecAddr, 32'hFD);
    @(negedge Clk);
    idle_inputs();
    tick();
    chk("c1_epc", bus.EPC, 32'hFFFF_FFFC);
    @(negedge Clk);
    bus.ExcReq  = 1'b1;
    bus.ExcCode = 2'b10;
    bus.PCWrite = 1'b1;
    bus.NextPC  = 32'h66;
    #1;
    chk("c1_fetch_addr", bus.ExcVecAddr, 32'hFD);
    tick();
    chk("c1_load_sel", {29'd0, bus.PCSrcSel}, 32'h4);
    @(negedge Clk);
    idle_inputs();
    tick();
    chk("c1_pc",   bus.PC,               32'h66);
    chk("c1_busy", {31'd0, bus.ExcBusy}, 32'h0);
    tick();
    chk("c1_ignored_busy", {31'd0, bus.ExcBusy}, 32'h0);
    chk("c1_ignored_epc",  bus.EPC,              32'hFFFF_FFFC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
